// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Results are computed at issue, held pending, and committed when the latency counter expires.
module muldiv_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [2:0]  MDOpE,
  input  logic [31:0] D1,
  input  logic [31:0] D2,
  input  logic        Cancel,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            r_state, w_state_next;
  logic [CntW-1:0]   r_cnt, w_cnt_next;
  logic [31:0]       r_hi, w_hi_next, r_lo, w_lo_next;
  logic [31:0]       r_hi_p, w_hi_p_next, r_lo_p, w_lo_p_next;
  logic              r_wr_p, w_wr_p_next;

  logic              w_ovf;
  logic [31:0]       w_sdivisor, w_udivisor;
  logic signed [31:0] w_squot, w_srem;
  logic [31:0]       w_uquot, w_urem;
  logic signed [63:0] w_sprod;
  logic [63:0]       w_uprod;

  // Divisor forced to 1 for x/0 (result discarded) and for the signed overflow case,
  // where dividing by 1 yields exactly the required LO=0x80000000, HI=0.
  assign w_ovf      = (D1 == 32'h8000_0000) && (D2 == 32'hFFFF_FFFF);
  assign w_sdivisor = ((D2 == 32'd0) || w_ovf) ? 32'd1 : D2;
  assign w_udivisor = (D2 == 32'd0) ? 32'd1 : D2;
  assign w_squot    = $signed(D1) / $signed(w_sdivisor);
  assign w_srem     = $signed(D1) % $signed(w_sdivisor);
  assign w_uquot    = D1 / w_udivisor;
  assign w_urem     = D1 % w_udivisor;
  assign w_sprod    = $signed({{32{D1[31]}}, D1}) * $signed({{32{D2[31]}}, D2});
  assign w_uprod    = {32'd0, D1} * {32'd0, D2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_hi_p  <= '0;
      r_lo_p  <= '0;
      r_wr_p  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      r_hi_p  <= w_hi_p_next;
      r_lo_p  <= w_lo_p_next;
      r_wr_p  <= w_wr_p_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    w_hi_p_next  = r_hi_p;
    w_lo_p_next  = r_lo_p;
    w_wr_p_next  = r_wr_p;
    case (r_state)
      StIdle: begin
        if (StartE && !Cancel) begin
          case (MDOpE)
            3'b001: begin
              w_state_next = StRun;
              w_cnt_next   = CntW'(MULT_CYCLES);
              {w_hi_p_next, w_lo_p_next} = w_sprod;
              w_wr_p_next  = 1'b1;
            end
            3'b010: begin
              w_state_next = StRun;
              w_cnt_next   = CntW'(MULT_CYCLES);
              {w_hi_p_next, w_lo_p_next} = w_uprod;
              w_wr_p_next  = 1'b1;
            end
            3'b011: begin
              w_state_next = StRun;
              w_cnt_next   = CntW'(DIV_CYCLES);
              w_hi_p_next  = w_srem;
              w_lo_p_next  = w_squot;
              w_wr_p_next  = (D2 != 32'd0);
            end
            3'b100: begin
              w_state_next = StRun;
              w_cnt_next   = CntW'(DIV_CYCLES);
              w_hi_p_next  = w_urem;
              w_lo_p_next  = w_uquot;
              w_wr_p_next  = (D2 != 32'd0);
            end
            3'b101:  w_hi_next = D1;
            3'b110:  w_lo_next = D1;
            default: ;
          endcase
        end
      end
      StRun: begin
        w_cnt_next = r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          w_state_next = StIdle;
          if (r_wr_p) begin
            w_hi_next = r_hi_p;
            w_lo_next = r_lo_p;
          end
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign Busy = (r_state == StRun);
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios followed by random traffic,
// compared cycle by cycle against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [2:0] OpNone  = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StartE = 1'b0;
  logic [2:0]  MDOpE = 3'd0;
  logic [31:0] D1 = '0;
  logic [31:0] D2 = '0;
  logic        Cancel = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  // Reference model: absolute cycle numbers, pending result captured at issue.
  longint      cyc = 0;
  bit          m_running = 0;
  longint      m_end = 0;
  bit          m_wr = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;

  muldiv_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .StartE(StartE),
    .MDOpE (MDOpE),
    .D1    (D1),
    .D2    (D2),
    .Cancel(Cancel),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_running = 0;
    m_wr = 0;
    m_hi = '0;
    m_lo = '0;
  endfunction

  function automatic void model_edge();
    int sa, sb;
    longint q, p;
    longint unsigned pu;
    cyc++;
    if (m_running) begin
      if (cyc == m_end) begin
        m_running = 0;
        if (m_wr) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
      end
    end else if (StartE && !Cancel) begin
      sa = D1;
      sb = D2;
      case (MDOpE)
        OpMult: begin
          p = longint'(sa) * longint'(sb);
          m_phi = p[63:32]; m_plo = p[31:0]; m_wr = 1;
          m_running = 1; m_end = cyc + MULT_N;
        end
        OpMultu: begin
          pu = longint'({32'd0, D1}) * longint'({32'd0, D2});
          m_phi = pu[63:32]; m_plo = pu[31:0]; m_wr = 1;
          m_running = 1; m_end = cyc + MULT_N;
        end
        OpDiv, OpDivu: begin
          m_running = 1; m_end = cyc + DIV_N;
          m_wr = (D2 != 0);
          if (D2 != 0) begin
            if (MDOpE == OpDiv) begin
              q = longint'(sa) / longint'(sb);
              p = longint'(sa) - q * longint'(sb);
            end else begin
              q = longint'({32'd0, D1}) / longint'({32'd0, D2});
              p = longint'({32'd0, D1}) - q * longint'({32'd0, D2});
            end
            m_plo = q[31:0];
            m_phi = p[31:0];
          end
        end
        OpMthi: m_hi = D1;
        OpMtlo: m_lo = D1;
        default: ;
      endcase
    end
  endfunction

  task automatic check_state(input string tag);
    checks++;
    assert (Busy === m_running)
    else begin errors++; $error("FAIL %s Busy got %b exp %b", tag, Busy, m_running); end
    checks++;
    assert (HI === m_hi)
    else begin errors++; $error("FAIL %s HI got %h exp %h", tag, HI, m_hi); end
    checks++;
    assert (LO === m_lo)
    else begin errors++; $error("FAIL %s LO got %h exp %h", tag, LO, m_lo); end
  endtask

  task automatic expect32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin errors++; $error("FAIL %s got %h exp %h", tag, got, exp); end
  endtask

  task automatic step(input logic st, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic cn, input string tag);
    @(negedge clk);
    StartE = st; MDOpE = op; D1 = a; D2 = b; Cancel = cn;
    @(posedge clk);
    model_edge();
    #1 check_state(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, OpNone, $urandom, $urandom, 1'b0, tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    StartE = 1'b0;
    reset = 1'b1;
    model_reset();
    #1 check_state(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  op;
    int          sel;

    #1 check_state("reset");
    #1 reset = 1'b0;

    step(1'b1, OpMult, 32'hFFFF_FFFF, 32'd2, 1'b0, "mult_issue");
    idle(MULT_N, "mult_run");
    expect32("mult_hi", HI, 32'hFFFF_FFFF);
    expect32("mult_lo", LO, 32'hFFFF_FFFE);

    step(1'b1, OpMultu, 32'hFFFF_FFFF, 32'd2, 1'b0, "multu_issue");
    idle(MULT_N, "multu_run");
    expect32("multu_hi", HI, 32'h0000_0001);

    step(1'b1, OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_issue");
    idle(DIV_N, "div_run");
    expect32("div_lo", LO, 32'hFFFF_FFFD);
    expect32("div_hi", HI, 32'hFFFF_FFFF);

    step(1'b1, OpDivu, 32'd7, 32'd2, 1'b0, "divu_issue");
    idle(DIV_N, "divu_run");
    expect32("divu_lo", LO, 32'd3);
    expect32("divu_hi", HI, 32'd1);

    step(1'b1, OpMthi, 32'h1234_5678, 32'd0, 1'b0, "mthi");
    expect32("mthi_hi", HI, 32'h1234_5678);
    step(1'b1, OpMtlo, 32'h9ABC_DEF0, 32'd0, 1'b0, "mtlo");
    expect32("mtlo_lo", LO, 32'h9ABC_DEF0);

    step(1'b1, OpMthi, 32'hAA, 32'd0, 1'b0, "pre_hi");
    step(1'b1, OpMtlo, 32'hBB, 32'd0, 1'b0, "pre_lo");
    step(1'b1, OpDiv, 32'd5, 32'd0, 1'b0, "div0_issue");
    idle(DIV_N, "div0_run");
    expect32("div0_hi", HI, 32'hAA);
    expect32("div0_lo", LO, 32'hBB);

    step(1'b1, OpMult, 32'd7, 32'd9, 1'b1, "cancel_issue");
    idle(2, "cancel_idle");

    step(1'b1, OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf_issue");
    idle(DIV_N, "ovf_run");
    expect32("ovf_lo", LO, 32'h8000_0000);
    expect32("ovf_hi", HI, 32'd0);

    step(1'b1, OpMult, 32'd3, 32'd4, 1'b0, "busy_issue");
    for (int i = 0; i < 3; i++) step(1'b1, OpDiv, 32'd9, 32'd3, 1'b0, "busy_restart");
    idle(2, "busy_run");
    expect32("busy_hi", HI, 32'd0);
    expect32("busy_lo", LO, 32'd12);

    step(1'b1, OpDiv, 32'd100, 32'd7, 1'b0, "rst_issue");
    idle(2, "rst_run");
    pulse_reset("rst_mid");
    idle(DIV_N + 2, "rst_after");
    step(1'b1, OpMult, 32'd2, 32'd3, 1'b0, "post_rst_issue");
    idle(MULT_N, "post_rst_run");
    expect32("post_rst_lo", LO, 32'd6);

    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
      op = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 3) != 0), op, a, b, ($urandom_range(0, 7) == 0), "random");
      if (i == 300) pulse_reset("random_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
